// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX drain controller: FSM encoding and
// default timing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    GAP     = 3'd4
  } drain_state_e;

  localparam int unsigned RD_LATENCY_DEF = 2;
  localparam int unsigned GAP_CYCLES_DEF = 0;

endpackage

// File: rtl/uart_tx_drain_ctrl_if.sv
// FIFO read port and transmitter handshake seen by the drain controller.
interface uart_tx_drain_ctrl_if;

  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_n;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_read_n, tx_valid, tx_data
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_read_n, tx_valid, tx_data
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset
// to RESET_VAL.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_tx_drain_ctrl.sv
// Read-side sequencer for the UART TX FIFO: fetches one byte at a time,
// presents it over valid/ready, with CTS gating, inter-byte gap and flush.
module uart_tx_drain_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   cts_n,
  input  logic                   flush,
  uart_tx_drain_ctrl_if.master   bus,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   sent_count
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  drain_state_e         state_d, state_q;
  logic [2:0]           lat_d, lat_q;
  logic [7:0]           gap_d, gap_q;
  logic                 discard_d, discard_q;
  logic                 rd_n_d, rd_n_q;
  logic                 valid_d, valid_q;
  logic [7:0]           data_d, data_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  logic cts_sync;
  logic cts_ok;
  logic handshake;

  uart_sync2 #(.RESET_VAL(1'b1)) u_cts_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (cts_n),
    .q       (cts_sync)
  );

  assign cts_ok    = !cts_sync;
  assign handshake = (state_q == PRESENT) && bus.tx_ready;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    gap_d     = gap_q;
    discard_d = discard_q;
    data_d    = data_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty && (flush || (enable && cts_ok))) state_d = READ;
      end
      READ: begin
        lat_d     = LAT_LOAD;
        discard_d = flush;
        state_d   = WAIT;
      end
      WAIT: begin
        // A flush seen anywhere in the read window turns this read into a discard.
        discard_d = discard_q | flush;
        if (lat_q == '0) begin
          if (discard_q || flush) begin
            state_d = IDLE;
          end else begin
            data_d  = bus.fifo_data;
            state_d = PRESENT;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      PRESENT: begin
        if (handshake) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (flush || (gap_q == '0)) state_d = IDLE;
        else                        gap_d   = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Strobe and valid are registered by decoding the next state.
    rd_n_d  = (state_d != READ);
    valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      gap_q     <= '0;
      discard_q <= 1'b0;
      rd_n_q    <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      gap_q     <= gap_d;
      discard_q <= discard_d;
      rd_n_q    <= rd_n_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.fifo_read_n = rd_n_q;
  assign bus.tx_valid    = valid_q;
  assign bus.tx_data     = data_q;
  assign sent_count      = cnt_q;
  assign busy            = (state_q != IDLE) || (flush && !bus.fifo_empty);

endmodule

// File: tb/tb_uart_tx_drain_ctrl.sv
// Directed bench for uart_tx_drain_ctrl: two instances (no gap, 10-cycle gap)
// each fed by a small latency-2 FIFO model.
module tb_uart_tx_drain_ctrl;

  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic enable   = 1'b1;
  logic cts_n    = 1'b0;
  logic flush    = 1'b0;
  logic tx_ready = 1'b1;

  always #5 clock = ~clock;

  uart_tx_drain_ctrl_if ifa ();
  uart_tx_drain_ctrl_if ifb ();

  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  uart_tx_drain_ctrl #(.RD_LATENCY(2), .GAP_CYCLES(0), .CNT_WIDTH(16)) dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .cts_n      (cts_n),
    .flush      (flush),
    .bus        (ifa),
    .busy       (busy_a),
    .sent_count (cnt_a)
  );

  uart_tx_drain_ctrl #(.RD_LATENCY(2), .GAP_CYCLES(10), .CNT_WIDTH(16)) dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .cts_n      (cts_n),
    .flush      (flush),
    .bus        (ifb),
    .busy       (busy_b),
    .sent_count (cnt_b)
  );

  // FIFO models: data valid two cycles after the strobe cycle.
  logic [7:0] mem   [2][64];
  logic [5:0] wp    [2] = '{6'd0, 6'd0};
  logic [5:0] rp    [2];
  logic [7:0] stage [2];
  logic [7:0] fdata [2];
  logic [1:0] rn, tv, bz;
  logic [7:0] td [2];

  assign rn    = {ifb.fifo_read_n, ifa.fifo_read_n};
  assign tv    = {ifb.tx_valid, ifa.tx_valid};
  assign bz    = {busy_b, busy_a};
  assign td[0] = ifa.tx_data;
  assign td[1] = ifb.tx_data;

  assign ifa.fifo_empty = (wp[0] == rp[0]);
  assign ifb.fifo_empty = (wp[1] == rp[1]);
  assign ifa.fifo_data  = fdata[0];
  assign ifb.fifo_data  = fdata[1];
  assign ifa.tx_ready   = tx_ready;
  assign ifb.tx_ready   = tx_ready;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        rp[i]    <= '0;
        stage[i] <= '0;
        fdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!rn[i] && (rp[i] != wp[i])) begin
          stage[i] <= mem[i][rp[i]];
          rp[i]    <= rp[i] + 6'd1;
        end
        fdata[i] <= stage[i];
      end
    end
  end

  // Event log sampled on the falling edge.
  int         cyc = 0;
  int         stb_cyc [2][64];
  int         nstb    [2] = '{0, 0};
  int         vr_cyc  [2][64];
  logic [7:0] vr_dat  [2][64];
  int         nvr     [2] = '{0, 0};
  int         hs_cyc  [2][64];
  int         nhs     [2] = '{0, 0};
  int         id_cyc  [2][64];
  int         nid     [2] = '{0, 0};
  logic [1:0] tv_prev = 2'b00;
  logic [1:0] id_pend = 2'b00;

  always @(negedge clock) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rn[i] && nstb[i] < 64) begin
        stb_cyc[i][nstb[i]] = cyc;
        nstb[i]++;
      end
      if (tv[i] && !tv_prev[i] && nvr[i] < 64) begin
        vr_cyc[i][nvr[i]] = cyc;
        vr_dat[i][nvr[i]] = td[i];
        nvr[i]++;
      end
      // tx_ready still holds the value it had during the previous cycle
      if (tv_prev[i] && tx_ready && nhs[i] < 64) begin
        hs_cyc[i][nhs[i]] = cyc - 1;
        nhs[i]++;
        id_pend[i] = 1'b1;
      end
      if (id_pend[i] && !bz[i] && nid[i] < 64) begin
        id_cyc[i][nid[i]] = cyc;
        nid[i]++;
        id_pend[i] = 1'b0;
      end
    end
    tv_prev = tv;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i]] = b;
    wp[i] = wp[i] + 6'd1;
  endtask

  task automatic wait_strobes(input int i, input int n, input int budget, input string tag);
    int k = 0;
    while (nstb[i] < n && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(nstb[i] >= n), 32'd1);
  endtask

  task automatic wait_vrise(input int i, input int n, input int budget, input string tag);
    int k = 0;
    while (nvr[i] < n && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(nvr[i] >= n), 32'd1);
  endtask

  task automatic wait_idle(input int i, input int budget, input string tag);
    int k = 0;
    while (bz[i] && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(bz[i]), 32'd0);
  endtask

  initial begin
    int s, v, h, c0, bad;

    // Reset values
    tick(2);
    check_eq("rst_read_n", 32'(ifa.fifo_read_n), 32'd1);
    check_eq("rst_valid", 32'(ifa.tx_valid), 32'd0);
    check_eq("rst_data", 32'(ifa.tx_data), 32'h00);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_count", 32'(cnt_a), 32'd0);
    reset_n = 1'b1;
    tick(4);

    // Three bytes back to back
    s = nstb[0]; v = nvr[0]; h = nhs[0];
    push(0, 8'hA5); push(0, 8'h3C); push(0, 8'hFF);
    wait_strobes(0, s + 3, 60, "t1_strobes_timeout");
    wait_idle(0, 40, "t1_idle_timeout");
    check_eq("t1_spacing_01", 32'(stb_cyc[0][s+1] - stb_cyc[0][s]), 32'd5);
    check_eq("t1_spacing_12", 32'(stb_cyc[0][s+2] - stb_cyc[0][s+1]), 32'd5);
    for (int k = 0; k < 3; k++)
      check_eq("t1_valid_lat", 32'(vr_cyc[0][v+k] - stb_cyc[0][s+k]), 32'd3);
    check_eq("t1_byte0", 32'(vr_dat[0][v]), 32'hA5);
    check_eq("t1_byte1", 32'(vr_dat[0][v+1]), 32'h3C);
    check_eq("t1_byte2", 32'(vr_dat[0][v+2]), 32'hFF);
    check_eq("t1_idle_after_hs", 32'(id_cyc[0][h+2] - hs_cyc[0][h+2]), 32'd1);
    check_eq("t1_count", 32'(cnt_a), 32'd3);
    check_eq("t1_busy", 32'(busy_a), 32'd0);
    check_eq("t1_empty", 32'(ifa.fifo_empty), 32'd1);

    // Transmitter stalls with two bytes queued
    tx_ready = 1'b0;
    s = nstb[0]; v = nvr[0];
    push(0, 8'h11); push(0, 8'h22);
    wait_vrise(0, v + 1, 30, "t2_valid_timeout");
    bad = 0;
    repeat (20) begin
      tick(1);
      if (!tv[0] || td[0] !== 8'h11) bad++;
    end
    check_eq("t2_hold_stable", 32'(bad), 32'd0);
    check_eq("t2_one_strobe", 32'(nstb[0] - s), 32'd1);
    c0 = cyc;
    tx_ready = 1'b1;
    wait_strobes(0, s + 2, 40, "t2_strobe2_timeout");
    check_eq("t2_strobe2_delay", 32'(stb_cyc[0][s+1] - c0), 32'd2);
    wait_idle(0, 40, "t2_idle_timeout");
    check_eq("t2_byte1", 32'(vr_dat[0][v+1]), 32'h22);
    check_eq("t2_count", 32'(cnt_a), 32'd5);

    // CTS deasserted holds off reads
    cts_n = 1'b1;
    tick(3);
    s = nstb[0];
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03); push(0, 8'h04);
    tick(50);
    check_eq("t3_no_strobe", 32'(nstb[0] - s), 32'd0);
    c0 = cyc;
    cts_n = 1'b0;
    wait_strobes(0, s + 1, 20, "t3_strobe_timeout");
    check_eq("t3_cts_delay", 32'(stb_cyc[0][s] - c0), 32'd3);
    wait_strobes(0, s + 4, 80, "t3_drain_timeout");
    wait_idle(0, 40, "t3_idle_timeout");
    check_eq("t3_count", 32'(cnt_a), 32'd9);

    // Inter-byte gap on the second instance
    s = nstb[1]; v = nvr[1]; h = nhs[1];
    push(1, 8'hB1); push(1, 8'hB2);
    wait_strobes(1, s + 2, 80, "t4_strobes_timeout");
    wait_idle(1, 60, "t4_idle_timeout");
    check_eq("t4_period", 32'(stb_cyc[1][s+1] - stb_cyc[1][s]), 32'd15);
    check_eq("t4_gap_len", 32'(id_cyc[1][h] - hs_cyc[1][h]), 32'd11);
    check_eq("t4_valid_lat", 32'(vr_cyc[1][v] - stb_cyc[1][s]), 32'd3);
    check_eq("t4_byte1", 32'(vr_dat[1][v+1]), 32'hB2);
    check_eq("t4_count", 32'(cnt_b), 32'd2);

    // Flush while the first byte is presented
    tx_ready = 1'b0;
    s = nstb[0]; v = nvr[0]; h = nhs[0];
    push(0, 8'h50); push(0, 8'h51); push(0, 8'h52); push(0, 8'h53); push(0, 8'h54);
    wait_vrise(0, v + 1, 30, "t5_valid_timeout");
    flush = 1'b1;
    tick(1);
    check_eq("t5_valid_drop", 32'(tv[0]), 32'd0);
    wait_idle(0, 80, "t5_idle_timeout");
    check_eq("t5_strobes", 32'(nstb[0] - s), 32'd5);
    check_eq("t5_no_valid", 32'(nvr[0] - v), 32'd1);
    check_eq("t5_no_hs", 32'(nhs[0] - h), 32'd0);
    check_eq("t5_count", 32'(cnt_a), 32'd9);
    check_eq("t5_empty", 32'(ifa.fifo_empty), 32'd1);
    check_eq("t5_data_kept", 32'(td[0]), 32'h50);
    flush = 1'b0;
    tx_ready = 1'b1;
    tick(2);

    // Reset during WAIT
    s = nstb[0];
    push(0, 8'h77);
    wait_strobes(0, s + 1, 20, "t6_strobe_timeout");
    tick(1);
    reset_n = 1'b0;
    wp[0] = '0;
    wp[1] = '0;
    #1;
    check_eq("t6_read_n", 32'(ifa.fifo_read_n), 32'd1);
    check_eq("t6_valid", 32'(ifa.tx_valid), 32'd0);
    check_eq("t6_data", 32'(ifa.tx_data), 32'h00);
    check_eq("t6_busy", 32'(busy_a), 32'd0);
    check_eq("t6_count_a", 32'(cnt_a), 32'd0);
    check_eq("t6_count_b", 32'(cnt_b), 32'd0);
    tick(2);
    reset_n = 1'b1;
    s = nstb[0];
    tick(12);
    check_eq("t6_no_strobe", 32'(nstb[0] - s), 32'd0);
    check_eq("t6_read_n_idle", 32'(ifa.fifo_read_n), 32'd1);
    check_eq("t6_busy_idle", 32'(busy_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
